// File: rtl/store_buffer.sv
// store_buffer: in-order store FIFO that drains one write per cycle to data memory; optional load forwarding under macro STORE_FWD_EN
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [7:0]               st_addr,
   input  logic [15:0]              st_data,
   input  logic                     drain_hold,
   output logic                     mem_signal_write,
   output logic [7:0]               mem_addr_write,
   output logic [15:0]              mem_data_write,
   input  logic [7:0]               ld_addr,
   output logic [7:0]               mem_addr_read,
   input  logic [15:0]              mem_data_read,
   output logic [15:0]              ld_data,
   output logic                     ld_fwd_hit,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0]    r_addr [DEPTH];
   logic [15:0]   r_data [DEPTH];
   logic [AW-1:0] r_head;
   logic [AW-1:0] r_tail;
   logic [AW:0]   r_count;
   logic          w_push;
   logic          w_pop;
   assign st_ready         = r_count != (AW+1)'(DEPTH);
   assign mem_signal_write = (r_count != '0) && !drain_hold;
   assign w_push           = st_valid && st_ready;
   assign w_pop            = mem_signal_write;
   assign mem_addr_write   = r_addr[r_head];
   assign mem_data_write   = r_data[r_head];
   assign mem_addr_read    = ld_addr;
   assign count            = r_count;
   assign empty            = r_count == '0;
   // pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH (power of two)
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_tail <= r_tail + 1'b1;
         if (w_pop) r_head <= r_head + 1'b1;
         r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
      end
   end
   // entry storage, written at tail on a push
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_addr[k] <= '0;
            r_data[k] <= '0;
         end
      end else if (w_push) begin
         r_addr[r_tail] <= st_addr;
         r_data[r_tail] <= st_data;
      end
   end
`ifdef STORE_FWD_EN
   // scan oldest to youngest so the youngest matching entry wins
   always_comb begin
      ld_data    = mem_data_read;
      ld_fwd_hit = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (((AW+1)'(k) < r_count) && (r_addr[r_head + AW'(k)] == ld_addr)) begin
            ld_data    = r_data[r_head + AW'(k)];
            ld_fwd_hit = 1'b1;
         end
      end
   end
`else
   assign ld_data    = mem_data_read;
   assign ld_fwd_hit = 1'b0;
`endif
endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered store entries; legal values are 2, 4 and 8.
REQ-002 Port clock, input, 1 bit: processor clock; all state changes on the rising edge.
REQ-003 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 Port st_valid, input, 1 bit: the execute stage presents a store.
REQ-005 Port st_ready, output, 1 bit: the buffer can accept a store this cycle.
REQ-006 Port st_addr, input, 8 bits: store word address.
REQ-007 Port st_data, input, 16 bits: store data.
REQ-008 Port drain_hold, input, 1 bit: when 1, the buffer issues no memory writes this cycle.
REQ-009 Port mem_signal_write, output, 1 bit: write strobe to data memory.
REQ-010 Port mem_addr_write, output, 8 bits: data memory write address.
REQ-011 Port mem_data_write, output, 16 bits: data memory write data.
REQ-012 Port ld_addr, input, 8 bits: load word address from the execute stage.
REQ-013 Port mem_addr_read, output, 8 bits: data memory read address.
REQ-014 Port mem_data_read, input, 16 bits: data memory combinational read data.
REQ-015 Port ld_data, output, 16 bits: load result.
REQ-016 Port ld_fwd_hit, output, 1 bit: ld_data was sourced from the buffer.
REQ-017 Port count, output, log2(DEPTH)+1 bits: number of valid entries.
REQ-018 Port empty, output, 1 bit: high when count is 0.

Function
REQ-019 The buffer SHALL be a circular FIFO of DEPTH {addr, data} entries with head and tail pointers that wrap modulo DEPTH.
REQ-020 st_ready SHALL equal (count != DEPTH) and SHALL NOT depend on a same-cycle drain.
REQ-021 A push SHALL occur on a clock edge where st_valid and st_ready are both 1; the entry is written at tail, and tail advances.
REQ-022 mem_signal_write SHALL equal (count != 0) and not drain_hold (combinational); mem_addr_write and mem_data_write SHALL show the head entry.
REQ-023 A pop SHALL occur on every edge where mem_signal_write is 1; head advances, giving a write latency of 1 cycle from head to memory.
REQ-024 On a simultaneous push and pop, count SHALL be unchanged and both pointers SHALL advance.
REQ-025 When the buffer is empty, a push SHALL NOT bypass to memory in the same cycle; the earliest memory write is the edge after the push.
REQ-026 Stores SHALL reach memory in program order; writes to the same address are never merged.
REQ-027 mem_addr_read SHALL equal ld_addr (combinational passthrough).
REQ-028 When the buffer is empty, or no valid entry matches, ld_data SHALL equal mem_data_read and ld_fwd_hit SHALL be 0 (subject to REQ-034).
REQ-029 With drain_hold held at 1, the buffer SHALL retain all entries and keep st_ready low once full.

Reset
REQ-030 While reset is 1, head, tail and count SHALL be 0, empty 1, st_ready 1, mem_signal_write 0, and ld_fwd_hit 0.
REQ-031 mem_addr_write, mem_data_write and the entry storage SHALL reset to 0.
REQ-032 Reset asserted mid-operation SHALL discard all pending stores; no memory write is issued in any cycle where reset is 1.

Configuration
REQ-033 With macro STORE_FWD_EN defined, ld_data SHALL return the data of the youngest valid entry whose addr equals ld_addr, with ld_fwd_hit 1; this includes the head entry being written on the current edge.
REQ-034 With STORE_FWD_EN undefined, ld_data SHALL always equal mem_data_read, ld_fwd_hit SHALL be tied to 0, and no comparators SHALL be instantiated.

Verification
REQ-035 Reset, then push {0x10, 0xBEEF}: the next cycle shows mem_signal_write=1, addr 0x10, data 0xBEEF; the cycle after shows count=0 and empty=1.
REQ-036 drain_hold=1 with 5 pushes and DEPTH=4: st_ready drops after the 4th push, count=4, and the 5th store is held; releasing the hold drains in order, 1 write per cycle.
REQ-037 STORE_FWD_EN with pushes {0x20, 0x1111} then {0x20, 0x2222} under hold, and ld_addr=0x20: ld_data=0x2222 and ld_fwd_hit=1; ld_addr=0x21 gives mem_data_read and hit=0.
REQ-038 Push and drain in the same cycle for 20 cycles: count stays constant, the pointers wrap past DEPTH-1, and the write sequence matches the push order.
REQ-039 Assert reset with count=3: count becomes 0 immediately (asynchronously), and no mem_signal_write occurs until a new push.
REQ-040 Build without STORE_FWD_EN and repeat REQ-037: ld_data equals mem_data_read and ld_fwd_hit stays 0.
